// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the IF/MEM memory bus arbiter.
// Covers FSM states, grant encoding and access size codes.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_INST = 1'b0,
        GNT_DATA = 1'b1
    } grant_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam int STARVE_W = 4;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// SRAM-like bus port (req/addr_ok/data_ok).
// The same interface type serves the IF port, the MEM port and the downstream bus.
interface mem_bus_arbiter_if;

    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );

endinterface

// File: rtl/mem_bus_arbiter_prio_sel.sv
// Winner select for the arbiter: data has priority unless inst has waited
// through STARVE_MAX consecutive data grants.
module arb_prio_sel
    import mem_bus_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   inst_req,
    input  logic   data_req,
    input  logic   arb_en,
    output grant_t winner
);

    localparam logic [STARVE_W-1:0] CNT_MAX = STARVE_W'(STARVE_MAX);

    logic [STARVE_W-1:0] starve_cnt;

    always_comb begin
        winner = GNT_INST;
        if (data_req && (!inst_req || starve_cnt != CNT_MAX)) begin
            winner = GNT_DATA;
        end
    end

    // Counts only data wins that made a waiting fetch wait longer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (arb_en && (inst_req || data_req)) begin
            if (winner == GNT_INST) begin
                starve_cnt <= '0;
            end else if (inst_req && starve_cnt != CNT_MAX) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-like bus between the IF fetch port and the MEM data port,
// one transaction outstanding, with fetch cancel on branch/flush.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    mem_bus_arbiter_if.slave    inst,
    input  logic                inst_cancel,
    mem_bus_arbiter_if.slave    data,
    mem_bus_arbiter_if.master   bus
);

    arb_state_t state, next_state;
    grant_t     grant;
    grant_t     winner;
    logic       cancel_pend;
    logic       any_req;
    logic       swallow;
    logic       unused_inst_fields;

    // The fetch port is read-only; its write-side fields are never forwarded.
    assign unused_inst_fields = ^{inst.wr, inst.size, inst.wstrb, inst.wdata};

    assign any_req = inst.req | data.req;
    assign swallow = cancel_pend | inst_cancel;

    arb_prio_sel #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio_sel (
        .clk      (clk),
        .rst      (rst),
        .inst_req (inst.req),
        .data_req (data.req),
        .arb_en   (state == ARB_IDLE),
        .winner   (winner)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ARB_IDLE;
            grant       <= GNT_INST;
            cancel_pend <= 1'b0;
        end else begin
            state <= next_state;
            if (state == ARB_IDLE && any_req) begin
                grant <= winner;
            end
            // An accepted fetch cannot be withdrawn, so remember to drop its data.
            if (state == ARB_DATA && bus.data_ok) begin
                cancel_pend <= 1'b0;
            end else if (state != ARB_IDLE && grant == GNT_INST && inst_cancel) begin
                cancel_pend <= 1'b1;
            end
        end
    end

    always_comb begin
        next_state   = state;
        bus.req      = 1'b0;
        bus.wr       = 1'b0;
        bus.size     = SZ_W;
        bus.wstrb    = 4'h0;
        bus.addr     = inst.addr;
        bus.wdata    = 32'h0;
        inst.addr_ok = 1'b0;
        inst.data_ok = 1'b0;
        inst.rdata   = 32'h0;
        data.addr_ok = 1'b0;
        data.data_ok = 1'b0;
        data.rdata   = 32'h0;

        if (grant == GNT_DATA) begin
            bus.wr    = data.wr;
            bus.size  = data.size;
            bus.wstrb = data.wstrb;
            bus.addr  = data.addr;
            bus.wdata = data.wdata;
        end

        case (state)
            ARB_IDLE: begin
                if (any_req) begin
                    next_state = ARB_ADDR;
                end
            end
            ARB_ADDR: begin
                bus.req = 1'b1;
                if (bus.addr_ok) begin
                    next_state = ARB_DATA;
                    if (grant == GNT_DATA) begin
                        data.addr_ok = 1'b1;
                    end else begin
                        inst.addr_ok = 1'b1;
                    end
                end
            end
            ARB_DATA: begin
                if (bus.data_ok) begin
                    next_state = ARB_IDLE;
                    if (grant == GNT_DATA) begin
                        data.data_ok = 1'b1;
                        data.rdata   = bus.rdata;
                    end else if (!swallow) begin
                        inst.data_ok = 1'b1;
                        inst.rdata   = bus.rdata;
                    end
                end
            end
            default: begin
                next_state = ARB_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a per-cycle vector table plus
// hand-written sequences for starvation, cancel, reset and stalled handshakes.
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    logic clk;
    logic rst;
    logic inst_cancel;

    mem_bus_arbiter_if inst_bus ();
    mem_bus_arbiter_if data_bus ();
    mem_bus_arbiter_if mem_bus ();

    int checks;
    int errors;

    mem_bus_arbiter #(
        .STARVE_MAX (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .inst        (inst_bus),
        .inst_cancel (inst_cancel),
        .data        (data_bus),
        .bus         (mem_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        inst_req;
        logic [31:0] inst_addr;
        logic        inst_cancel;
        logic        data_req;
        logic        data_wr;
        logic [1:0]  data_size;
        logic [3:0]  data_wstrb;
        logic [31:0] data_addr;
        logic [31:0] data_wdata;
        logic        bus_addr_ok;
        logic        bus_data_ok;
        logic [31:0] bus_rdata;
        logic        exp_bus_req;
        logic        exp_bus_wr;
        logic [1:0]  exp_bus_size;
        logic [3:0]  exp_bus_wstrb;
        logic [31:0] exp_bus_addr;
        logic [31:0] exp_bus_wdata;
        logic        exp_inst_addr_ok;
        logic        exp_inst_data_ok;
        logic [31:0] exp_inst_rdata;
        logic        exp_data_addr_ok;
        logic        exp_data_data_ok;
        logic [31:0] exp_data_rdata;
    } vec_t;

    localparam int NUM_VECS = 17;
    vec_t vecs [NUM_VECS];

    // A requester must hold req through a stalled address phase.
    assert property (@(posedge clk) disable iff (!rst)
        (mem_bus.req && !mem_bus.addr_ok) |=> (inst_bus.req || data_bus.req))
        else $error("[TB] requester dropped req during address phase");

    always @(posedge clk) begin
        if (rst) begin
            assert (!(inst_bus.addr_ok && data_bus.addr_ok))
                else $error("[TB] both addr_ok outputs high");
            assert (!(inst_bus.data_ok && data_bus.data_ok))
                else $error("[TB] both data_ok outputs high");
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic idle_inputs();
        rst              = 1'b1;
        inst_cancel      = 1'b0;
        inst_bus.req     = 1'b0;
        inst_bus.wr      = 1'b0;
        inst_bus.size    = SZ_W;
        inst_bus.wstrb   = 4'h0;
        inst_bus.addr    = 32'h0;
        inst_bus.wdata   = 32'h0;
        data_bus.req     = 1'b0;
        data_bus.wr      = 1'b0;
        data_bus.size    = SZ_W;
        data_bus.wstrb   = 4'h0;
        data_bus.addr    = 32'h0;
        data_bus.wdata   = 32'h0;
        mem_bus.addr_ok  = 1'b0;
        mem_bus.data_ok  = 1'b0;
        mem_bus.rdata    = 32'h0;
    endtask

    task automatic apply_stimulus(input vec_t v);
        rst             = v.rst;
        inst_bus.req    = v.inst_req;
        inst_bus.addr   = v.inst_addr;
        inst_cancel     = v.inst_cancel;
        data_bus.req    = v.data_req;
        data_bus.wr     = v.data_wr;
        data_bus.size   = v.data_size;
        data_bus.wstrb  = v.data_wstrb;
        data_bus.addr   = v.data_addr;
        data_bus.wdata  = v.data_wdata;
        mem_bus.addr_ok = v.bus_addr_ok;
        mem_bus.data_ok = v.bus_data_ok;
        mem_bus.rdata   = v.bus_rdata;
    endtask

    // One fetch; cancel_at: 0 none, 1 ADDR before accept, 2 with addr_ok, 3 DATA before data_ok, 4 with data_ok.
    task automatic inst_txn(input logic [31:0] addr, input int cancel_at, input int aok_delay,
                            input logic [31:0] rdata, input logic exp_dok, input string tag);
        @(negedge clk);
        idle_inputs();
        inst_bus.req  = 1'b1;
        inst_bus.addr = addr;
        #1 check_output({tag, "_idle_bus_req"}, mem_bus.req, 0);
        for (int i = 0; i < aok_delay; i++) begin
            @(negedge clk);
            inst_cancel = (cancel_at == 1 && i == 0);
            #1 check_output({tag, "_wait_bus_req"}, mem_bus.req, 1);
            check_output({tag, "_wait_inst_addr_ok"}, inst_bus.addr_ok, 0);
        end
        @(negedge clk);
        inst_cancel     = (cancel_at == 2);
        mem_bus.addr_ok = 1'b1;
        #1 check_output({tag, "_bus_addr"}, mem_bus.addr, addr);
        check_output({tag, "_bus_wr"}, mem_bus.wr, 0);
        check_output({tag, "_inst_addr_ok"}, inst_bus.addr_ok, 1);
        check_output({tag, "_data_addr_ok"}, data_bus.addr_ok, 0);
        @(negedge clk);
        inst_bus.req    = 1'b0;
        inst_cancel     = (cancel_at == 3);
        mem_bus.addr_ok = 1'b0;
        #1 check_output({tag, "_early_inst_data_ok"}, inst_bus.data_ok, 0);
        @(negedge clk);
        inst_cancel     = (cancel_at == 4);
        mem_bus.data_ok = 1'b1;
        mem_bus.rdata   = rdata;
        #1 check_output({tag, "_inst_data_ok"}, inst_bus.data_ok, exp_dok);
        check_output({tag, "_inst_rdata"}, inst_bus.rdata, exp_dok ? rdata : 32'h0);
        check_output({tag, "_data_data_ok"}, data_bus.data_ok, 0);
        @(negedge clk);
        idle_inputs();
    endtask

    // One data access with aok_delay stalled address cycles; addr_ok must pulse exactly once.
    task automatic data_txn(input logic [31:0] addr, input logic wr, input logic [1:0] size,
                            input logic [3:0] wstrb, input logic [31:0] wdata, input int aok_delay,
                            input logic [31:0] rdata, input string tag);
        int pulses;
        pulses = 0;
        @(negedge clk);
        idle_inputs();
        data_bus.req   = 1'b1;
        data_bus.wr    = wr;
        data_bus.size  = size;
        data_bus.wstrb = wstrb;
        data_bus.addr  = addr;
        data_bus.wdata = wdata;
        #1 check_output({tag, "_idle_bus_req"}, mem_bus.req, 0);
        for (int i = 0; i <= aok_delay; i++) begin
            @(negedge clk);
            mem_bus.addr_ok = (i == aok_delay);
            #1 check_output({tag, "_bus_req"}, mem_bus.req, 1);
            check_output({tag, "_bus_addr"}, mem_bus.addr, addr);
            check_output({tag, "_bus_wdata"}, mem_bus.wdata, wdata);
            check_output({tag, "_bus_fields"}, {mem_bus.wr, mem_bus.size, mem_bus.wstrb}, {wr, size, wstrb});
            check_output({tag, "_data_addr_ok"}, data_bus.addr_ok, (i == aok_delay));
            pulses += int'(data_bus.addr_ok);
        end
        @(negedge clk);
        data_bus.req    = 1'b0;
        mem_bus.addr_ok = 1'b0;
        #1 pulses += int'(data_bus.addr_ok);
        check_output({tag, "_early_data_data_ok"}, data_bus.data_ok, 0);
        @(negedge clk);
        mem_bus.data_ok = 1'b1;
        mem_bus.rdata   = rdata;
        #1 pulses += int'(data_bus.addr_ok);
        check_output({tag, "_data_data_ok"}, data_bus.data_ok, 1);
        check_output({tag, "_data_rdata"}, data_bus.rdata, rdata);
        check_output({tag, "_inst_data_ok"}, inst_bus.data_ok, 0);
        check_output({tag, "_addr_ok_pulses"}, 32'(pulses), 1);
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // rst, ireq, iaddr, icancel, dreq, dwr, dsize, dwstrb, daddr, dwdata, baok, bdok, brdata | expected outputs
        vecs[0]  = '{0, 1, 32'h1C00_0000, 0, 0, 0, SZ_W, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0,
                     0, 0, SZ_W, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0};
        vecs[1]  = '{1, 1, 32'h1C00_0000, 0, 0, 0, SZ_W, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0,
                     0, 0, SZ_W, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0};
        vecs[2]  = '{1, 1, 32'h1C00_0000, 0, 0, 0, SZ_W, 4'h0, 32'h0, 32'h0, 1, 0, 32'h0,
                     1, 0, SZ_W, 4'h0, 32'h1C00_0000, 32'h0, 1, 0, 32'h0, 0, 0, 32'h0};
        vecs[3]  = '{1, 0, 32'h1C00_0000, 0, 0, 0, SZ_W, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0,
                     0, 0, SZ_W, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0};
        vecs[4]  = '{1, 0, 32'h1C00_0000, 0, 0, 0, SZ_W, 4'h0, 32'h0, 32'h0, 0, 1, 32'h0280_0000,
                     0, 0, SZ_W, 4'h0, 32'h0, 32'h0, 0, 1, 32'h0280_0000, 0, 0, 32'h0};
        vecs[5]  = '{1, 1, 32'h1C00_0100, 0, 1, 1, SZ_W, 4'hF, 32'h1C00_8000, 32'hDEAD_BEEF, 0, 0, 32'h0,
                     0, 0, SZ_W, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0};
        vecs[6]  = '{1, 1, 32'h1C00_0100, 0, 1, 1, SZ_W, 4'hF, 32'h1C00_8000, 32'hDEAD_BEEF, 1, 0, 32'h0,
                     1, 1, SZ_W, 4'hF, 32'h1C00_8000, 32'hDEAD_BEEF, 0, 0, 32'h0, 1, 0, 32'h0};
        vecs[7]  = '{1, 1, 32'h1C00_0100, 0, 0, 0, SZ_W, 4'h0, 32'h0, 32'h0, 0, 1, 32'hAAAA_5555,
                     0, 0, SZ_W, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0, 0, 1, 32'hAAAA_5555};
        vecs[8]  = '{1, 1, 32'h1C00_0100, 0, 0, 0, SZ_W, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0,
                     0, 0, SZ_W, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0};
        vecs[9]  = '{1, 1, 32'h1C00_0100, 0, 0, 0, SZ_W, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0,
                     1, 0, SZ_W, 4'h0, 32'h1C00_0100, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0};
        vecs[10] = '{1, 1, 32'h1C00_0100, 0, 0, 0, SZ_W, 4'h0, 32'h0, 32'h0, 1, 0, 32'h0,
                     1, 0, SZ_W, 4'h0, 32'h1C00_0100, 32'h0, 1, 0, 32'h0, 0, 0, 32'h0};
        vecs[11] = '{1, 0, 32'h1C00_0100, 0, 0, 0, SZ_W, 4'h0, 32'h0, 32'h0, 0, 1, 32'h0000_1111,
                     0, 0, SZ_W, 4'h0, 32'h0, 32'h0, 0, 1, 32'h0000_1111, 0, 0, 32'h0};
        vecs[12] = '{1, 0, 32'h0, 0, 0, 0, SZ_W, 4'h0, 32'h0, 32'h0, 1, 1, 32'hFFFF_FFFF,
                     0, 0, SZ_W, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0};
        vecs[13] = '{1, 0, 32'h0, 0, 1, 0, SZ_B, 4'h0, 32'h1C00_8003, 32'h0, 0, 0, 32'h0,
                     0, 0, SZ_W, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0};
        vecs[14] = '{1, 0, 32'h0, 0, 1, 0, SZ_B, 4'h0, 32'h1C00_8003, 32'h0, 0, 1, 32'hFFFF_FFFF,
                     1, 0, SZ_B, 4'h0, 32'h1C00_8003, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0};
        vecs[15] = '{1, 0, 32'h0, 0, 1, 0, SZ_B, 4'h0, 32'h1C00_8003, 32'h0, 1, 0, 32'h0,
                     1, 0, SZ_B, 4'h0, 32'h1C00_8003, 32'h0, 0, 0, 32'h0, 1, 0, 32'h0};
        vecs[16] = '{1, 0, 32'h0, 1, 0, 0, SZ_W, 4'h0, 32'h0, 32'h0, 0, 1, 32'h0000_00AB,
                     0, 0, SZ_W, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0, 0, 1, 32'h0000_00AB};

        idle_inputs();
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] vector table");
        for (int i = 0; i < NUM_VECS; i++) begin
            @(negedge clk);
            apply_stimulus(vecs[i]);
            #1;
            check_output($sformatf("v%0d_bus_req", i), mem_bus.req, vecs[i].exp_bus_req);
            if (vecs[i].exp_bus_req) begin
                check_output($sformatf("v%0d_bus_wr", i), mem_bus.wr, vecs[i].exp_bus_wr);
                check_output($sformatf("v%0d_bus_size", i), mem_bus.size, vecs[i].exp_bus_size);
                check_output($sformatf("v%0d_bus_wstrb", i), mem_bus.wstrb, vecs[i].exp_bus_wstrb);
                check_output($sformatf("v%0d_bus_addr", i), mem_bus.addr, vecs[i].exp_bus_addr);
                check_output($sformatf("v%0d_bus_wdata", i), mem_bus.wdata, vecs[i].exp_bus_wdata);
            end
            check_output($sformatf("v%0d_inst_addr_ok", i), inst_bus.addr_ok, vecs[i].exp_inst_addr_ok);
            check_output($sformatf("v%0d_inst_data_ok", i), inst_bus.data_ok, vecs[i].exp_inst_data_ok);
            check_output($sformatf("v%0d_inst_rdata", i), inst_bus.rdata, vecs[i].exp_inst_rdata);
            check_output($sformatf("v%0d_data_addr_ok", i), data_bus.addr_ok, vecs[i].exp_data_addr_ok);
            check_output($sformatf("v%0d_data_data_ok", i), data_bus.data_ok, vecs[i].exp_data_data_ok);
            check_output($sformatf("v%0d_data_rdata", i), data_bus.rdata, vecs[i].exp_data_rdata);
        end

        $display("[TB] starvation: expect D D D D I D I");
        @(negedge clk);
        idle_inputs();
        for (int r = 0; r < 7; r++) begin
            logic        exp_data;
            logic [31:0] daddr;
            exp_data = (r < 4) || (r == 5);
            daddr    = 32'h1C00_8000 + 32'(r * 4);
            @(negedge clk);
            inst_bus.req    = 1'b1;
            inst_bus.addr   = 32'h1C00_0200;
            data_bus.req    = (r < 6);
            data_bus.wr     = 1'b0;
            data_bus.size   = SZ_W;
            data_bus.addr   = daddr;
            mem_bus.addr_ok = 1'b0;
            mem_bus.data_ok = 1'b0;
            #1 check_output($sformatf("starve%0d_idle_bus_req", r), mem_bus.req, 0);
            @(negedge clk);
            mem_bus.addr_ok = 1'b1;
            #1 check_output($sformatf("starve%0d_bus_req", r), mem_bus.req, 1);
            check_output($sformatf("starve%0d_bus_addr", r), mem_bus.addr, exp_data ? daddr : 32'h1C00_0200);
            check_output($sformatf("starve%0d_data_addr_ok", r), data_bus.addr_ok, exp_data);
            check_output($sformatf("starve%0d_inst_addr_ok", r), inst_bus.addr_ok, !exp_data);
            @(negedge clk);
            mem_bus.addr_ok = 1'b0;
            mem_bus.data_ok = 1'b1;
            mem_bus.rdata   = 32'h100 + 32'(r);
            if (exp_data) data_bus.req = 1'b0;
            else          inst_bus.req = 1'b0;
            #1 check_output($sformatf("starve%0d_data_data_ok", r), data_bus.data_ok, exp_data);
            check_output($sformatf("starve%0d_inst_data_ok", r), inst_bus.data_ok, !exp_data);
        end

        $display("[TB] fetch cancel");
        inst_txn(32'h1C00_0300, 3, 0, 32'h1234_5678, 1'b0, "cancel_data");
        data_txn(32'h1C00_8010, 1'b0, SZ_W, 4'h0, 32'h0, 0, 32'h8765_4321, "after_cancel");
        inst_txn(32'h1C00_0304, 1, 2, 32'h1111_2222, 1'b0, "cancel_addr");
        inst_txn(32'h1C00_0308, 2, 0, 32'h3333_4444, 1'b0, "cancel_aok");
        inst_txn(32'h1C00_030C, 4, 0, 32'h5555_6666, 1'b0, "cancel_dok");
        inst_txn(32'h1C00_0310, 0, 1, 32'h7777_8888, 1'b1, "no_cancel");

        $display("[TB] reset during data phase");
        @(negedge clk);
        idle_inputs();
        inst_bus.req  = 1'b1;
        inst_bus.addr = 32'h1C00_0400;
        @(negedge clk);
        mem_bus.addr_ok = 1'b1;
        #1 check_output("rst_pre_inst_addr_ok", inst_bus.addr_ok, 1);
        @(negedge clk);
        inst_bus.req    = 1'b0;
        mem_bus.addr_ok = 1'b0;
        rst             = 1'b0;
        @(negedge clk);
        rst             = 1'b1;
        mem_bus.data_ok = 1'b1;
        mem_bus.rdata   = 32'hDEAD_DEAD;
        #1 check_output("rst_bus_req", mem_bus.req, 0);
        check_output("rst_inst_data_ok", inst_bus.data_ok, 0);
        check_output("rst_inst_rdata", inst_bus.rdata, 0);
        check_output("rst_data_data_ok", data_bus.data_ok, 0);
        check_output("rst_addr_oks", {inst_bus.addr_ok, data_bus.addr_ok}, 0);
        inst_txn(32'h1C00_0404, 0, 0, 32'h600D_600D, 1'b1, "post_rst");

        $display("[TB] stalled address handshake");
        data_txn(32'h1C00_8020, 1'b1, SZ_H, 4'b0011, 32'h5A5A_1234, 5, 32'h0, "stall");

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
